// File: rtl/ultrasonic_range_sched.sv
// Ultrasonic ranging scheduler: periodic trigger, echo timing, cm conversion,
// timeout detection and a hysteretic obstacle flag for motor arbitration.
module ultrasonic_range_sched #(
  parameter int CLK_DIV    = 50,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_US  = 60000,
  parameter int TIMEOUT_US = 25000,
  parameter int US_PER_CM  = 58,
  parameter int STOP_CM    = 20,
  parameter int GO_CM      = 25,
  parameter int DIST_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] distance,
  output logic              dist_valid,
  output logic              timeout,
  output logic              obstacle,
  output logic              busy
);

  localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PERW = $clog2(PERIOD_US + 1);
  localparam int CMAX = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int UW   = $clog2(US_PER_CM + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLD
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     pre_q;
  logic              tick;
  logic [2:0]        sync_q;
  logic              rise;
  logic              fall;
  logic [PERW-1:0]   per_q;
  logic [CW-1:0]     cnt_q;
  logic [UW-1:0]     us_q;
  logic [UW-1:0]     us_d;
  logic [DIST_W-1:0] cm_q;
  logic [DIST_W-1:0] cm_d;
  logic              trig_q;
  logic [DIST_W-1:0] dist_q;
  logic              dv_q;
  logic              to_q;
  logic              obs_q;

  assign tick = (pre_q == PW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // sync_q[1] is the synchronised echo, sync_q[2] its previous value
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], echo};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

  // Includes the current tick so a falling edge captures the full width
  always_comb begin
    us_d = us_q;
    cm_d = cm_q;
    if (tick) begin
      if (us_q == UW'(US_PER_CM - 1)) begin
        us_d = '0;
        if (cm_q != {DIST_W{1'b1}}) begin
          cm_d = cm_q + 1'b1;
        end
      end else begin
        us_d = us_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      trig_q  <= 1'b0;
      dist_q  <= '0;
      dv_q    <= 1'b0;
      to_q    <= 1'b0;
      obs_q   <= 1'b0;
      per_q   <= '0;
      cnt_q   <= '0;
      us_q    <= '0;
      cm_q    <= '0;
    end else begin
      dv_q <= 1'b0;
      to_q <= 1'b0;
      if (state_q != S_IDLE && tick) begin
        per_q <= per_q + 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (enable && tick) begin
            state_q <= S_TRIG;
            trig_q  <= 1'b1;
            per_q   <= '0;
            cnt_q   <= '0;
          end
        end
        S_TRIG: begin
          if (!enable) begin
            state_q <= S_IDLE;
            trig_q  <= 1'b0;
          end else if (tick) begin
            if (cnt_q == CW'(TRIG_US - 1)) begin
              trig_q  <= 1'b0;
              state_q <= S_WAIT_RISE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_WAIT_RISE: begin
          if (!enable) begin
            state_q <= S_IDLE;
          end else if (rise) begin
            state_q <= S_MEASURE;
            cnt_q   <= '0;
            us_q    <= '0;
            cm_q    <= '0;
          end else if (tick) begin
            if (cnt_q == CW'(TIMEOUT_US - 1)) begin
              to_q    <= 1'b1;
              obs_q   <= 1'b0;
              state_q <= S_HOLD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_MEASURE: begin
          if (!enable) begin
            state_q <= S_IDLE;
          end else if (fall) begin
            dist_q  <= cm_d;
            dv_q    <= 1'b1;
            state_q <= S_HOLD;
            if (cm_d < DIST_W'(STOP_CM)) begin
              obs_q <= 1'b1;
            end else if (cm_d >= DIST_W'(GO_CM)) begin
              obs_q <= 1'b0;
            end
          end else if (tick) begin
            us_q <= us_d;
            cm_q <= cm_d;
            if (cnt_q == CW'(TIMEOUT_US - 1)) begin
              to_q    <= 1'b1;
              obs_q   <= 1'b0;
              state_q <= S_HOLD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (tick && per_q >= PERW'(PERIOD_US - 1)) begin
            per_q <= '0;
            cnt_q <= '0;
            if (enable) begin
              state_q <= S_TRIG;
              trig_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          trig_q  <= 1'b0;
        end
      endcase
    end
  end

  assign trig       = trig_q;
  assign distance   = dist_q;
  assign dist_valid = dv_q;
  assign timeout    = to_q;
  assign obstacle   = obs_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ultrasonic_range_sched.sv
// Bench for ultrasonic_range_sched: directed and random echo widths
// against an arithmetic distance/obstacle model.
module tb_ultrasonic_range_sched;

  localparam int TRIG    = 10;
  localparam int PERIOD  = 4500;
  localparam int TMO     = 2000;
  localparam int CM_US   = 58;
  localparam int STOP    = 20;
  localparam int GO      = 25;
  localparam int DW      = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          echo = 1'b0;
  logic          trig;
  logic [DW-1:0] distance;
  logic          dist_valid;
  logic          timeout;
  logic          obstacle;
  logic          busy;

  ultrasonic_range_sched #(
    .CLK_DIV   (1),
    .TRIG_US   (TRIG),
    .PERIOD_US (PERIOD),
    .TIMEOUT_US(TMO),
    .US_PER_CM (CM_US),
    .STOP_CM   (STOP),
    .GO_CM     (GO),
    .DIST_W    (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .echo      (echo),
    .trig      (trig),
    .distance  (distance),
    .dist_valid(dist_valid),
    .timeout   (timeout),
    .obstacle  (obstacle),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0d", tag, got, exp, cyc);
    end
  endtask

  int strobe_cnt = 0;
  bit last_dv;
  bit last_to;
  int last_t;

  always begin
    @(posedge clk);
    #1;
    if (!rst && (dist_valid || timeout)) begin
      strobe_cnt++;
      last_dv = dist_valid;
      last_to = timeout;
      last_t  = cyc;
      chk("excl", {31'd0, dist_valid & timeout}, 0);
    end
  end

  int dist_m = 0;
  bit obs_m  = 1'b0;
  int prev_rise = -1;
  int prev_s = -1;

  task automatic wait_trig(input bit lvl, output int t);
    bit seen = 1'b0;
    for (int i = 0; i < PERIOD + 200; i++) begin
      @(negedge clk);
      if (trig === lvl) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("trig_wait", 0, 1);
    t = cyc;
  endtask

  task automatic wait_strobe(input int s0);
    bit seen = 1'b0;
    for (int i = 0; i < 3 * TMO + 100; i++) begin
      if (strobe_cnt != s0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) chk("strobe_wait", 0, 1);
  endtask

  task automatic cycle_start(output int tr);
    wait_trig(1'b1, tr);
    if (prev_rise >= 0) chk("period", tr - prev_rise, PERIOD);
    if (prev_s >= 0) chk("nstrobe", strobe_cnt - prev_s, 1);
    prev_rise = tr;
    prev_s    = strobe_cnt;
  endtask

  // hi=0: no echo; pre: echo raised during the trigger pulse
  task automatic run_cycle(input int dly, input int hi, input bit pre);
    int tr, tf, te, s0;
    bit valid;
    te = 0;
    cycle_start(tr);
    s0 = strobe_cnt;
    if (pre) echo = 1'b1;
    wait_trig(1'b0, tf);
    chk("trig_w", tf - tr, TRIG);
    if (hi > 0) begin
      repeat (dly) @(negedge clk);
      echo = 1'b1;
      repeat (hi) @(negedge clk);
      echo = 1'b0;
      te = cyc;
    end
    wait_strobe(s0);
    valid = (hi > 0) && (hi < TMO) && !pre;
    if (valid) begin
      dist_m = hi / CM_US;
      if (dist_m > 511) dist_m = 511;
      if (dist_m < STOP) obs_m = 1'b1;
      else if (dist_m >= GO) obs_m = 1'b0;
      chk("is_dv", {31'd0, last_dv}, 1);
      chk("dv_lat", last_t - te, 3);
    end else begin
      obs_m = 1'b0;
      chk("is_to", {31'd0, last_to}, 1);
      if (hi == 0) chk("to_lat", last_t - tf, TMO);
    end
    chk("dist", {23'd0, distance}, dist_m);
    chk("obst", {31'd0, obstacle}, {31'd0, obs_m});
    chk("busy", {31'd0, busy}, 1);
    if (pre) echo = 1'b0;
  endtask

  task automatic run_abort();
    int tr, tf, s0;
    cycle_start(tr);
    wait_trig(1'b0, tf);
    repeat (20) @(negedge clk);
    echo = 1'b1;
    repeat (503) @(negedge clk);
    s0 = strobe_cnt;
    enable = 1'b0;
    @(negedge clk);
    chk("ab_trig", {31'd0, trig}, 0);
    chk("ab_busy", {31'd0, busy}, 0);
    repeat (50) @(negedge clk);
    echo = 1'b0;
    repeat (50) @(negedge clk);
    chk("ab_nostrobe", strobe_cnt - s0, 0);
    chk("ab_dist", {23'd0, distance}, dist_m);
    chk("ab_obst", {31'd0, obstacle}, {31'd0, obs_m});
    chk("ab_idle", {31'd0, busy}, 0);
    prev_rise = -1;
    prev_s    = -1;
    enable    = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_trig"}, {31'd0, trig}, 0);
    chk({tag, "_dist"}, {23'd0, distance}, 0);
    chk({tag, "_dv"}, {31'd0, dist_valid}, 0);
    chk({tag, "_to"}, {31'd0, timeout}, 0);
    chk({tag, "_obst"}, {31'd0, obstacle}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    int tr, tf;
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      echo = $urandom_range(0, 1);
    end
    check_reset("rst");
    echo = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_cycle(50, 1160, 1'b0);
    run_cycle(80, 1102, 1'b0);
    run_cycle(60, 1392, 1'b0);
    run_cycle(70, 1450, 1'b0);
    run_cycle(40, 1102, 1'b0);
    run_cycle(0, 0, 1'b0);
    run_cycle(30, 580, 1'b0);
    run_cycle(30, TMO + 500, 1'b0);
    run_cycle(0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_cycle($urandom_range(5, 200),
                $urandom_range(CM_US, 1950), 1'b0);
    end
    run_abort();
    run_cycle(25, 812, 1'b0);

    cycle_start(tr);
    wait_trig(1'b0, tf);
    repeat (20) @(negedge clk);
    echo = 1'b1;
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_rst");
    echo = 1'b0;
    rst  = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
